// File: rtl/rx_ipv4.sv
// -----------------------------------------------------------------------------
// rx_ipv4 -- IPv4 header parser / payload extractor
//
// Receives one IPv4 datagram per rx_data_v burst (Ethertype already stripped),
// validates the header (version, IHL, total length, protocol, header checksum,
// destination address) and forwards only the payload bytes, one cycle late.
// Ethernet padding / FCS beyond total_len is never forwarded.
//
// Parameters
//   OCT    byte width of the data path (protocol fields assume 8)
//   PROTO  accepted IPv4 protocol number (default UDP)
//
// Ports
//   RX_CLK        receive clock, all logic on its rising edge
//   rst_n         asynchronous active-low reset
//   my_ip         local IPv4 address (quasi-static)
//   rx_data_v     high for the whole datagram, low >= 1 cycle between frames
//   rx_data       datagram byte, network order
//   rx_ip_data_v  payload byte valid, contiguous per datagram
//   rx_ip_data    payload byte (holds when rx_ip_data_v is low)
//   rx_src_ip     source address of the last accepted datagram
//   rx_drop       1-cycle pulse when a complete header is rejected
// -----------------------------------------------------------------------------
module rx_ipv4 #(
    parameter int             OCT   = 8,
    parameter logic [OCT-1:0] PROTO = 8'h11
) (
    input  logic               RX_CLK,
    input  logic               rst_n,
    input  logic [OCT*4-1:0]   my_ip,
    input  logic               rx_data_v,
    input  logic [OCT-1:0]     rx_data,
    output logic               rx_ip_data_v,
    output logic [OCT-1:0]     rx_ip_data,
    output logic [OCT*4-1:0]   rx_src_ip,
    output logic               rx_drop
);

    localparam int W2 = 2 * OCT;

    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } state_t;

    // One's-complement add with the end-around carry folded back in.
    function automatic logic [W2-1:0] ones_add(input logic [W2-1:0] a,
                                               input logic [W2-1:0] b);
        logic [W2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W2-1:0] + {{(W2-1){1'b0}}, s[W2]};
    endfunction

    // Byte counter saturates instead of wrapping on oversized bursts.
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;

    logic [15:0]        r_cnt;
    logic [W2-1:0]      r_sum;
    logic [OCT-1:0]     r_hi;
    logic [3:0]         r_ver;
    logic [3:0]         r_ihl;
    logic [W2-1:0]      r_tlen;
    logic [OCT-1:0]     r_proto;
    logic [4*OCT-1:0]   r_src;
    logic [4*OCT-1:0]   r_dst;
    logic               r_armed;

    logic               r_ip_v;
    logic [OCT-1:0]     r_ip_data;
    logic [4*OCT-1:0]   r_src_ip;
    logic               r_drop;

    logic [15:0]        w_hdr_len;
    logic [15:0]        w_hdr_last;
    logic [15:0]        w_tlen16;
    logic [W2-1:0]      w_sum_nxt;
    logic [4*OCT-1:0]   w_dst_now;
    logic               w_active;
    logic               w_hdr_end;
    logic               w_hdr_ok;
    logic               w_accept;
    logic               w_reject;
    logic               w_pay_last;
    logic               w_fwd;

    // After reset the parser stays idle until a low rx_data_v has been seen,
    // so a frame that was cut by reset is never parsed from its middle.
    assign w_active   = rx_data_v && r_armed;

    assign w_hdr_len  = {10'd0, r_ihl, 2'b00};
    // A malformed IHL (<5) is still judged at the end of the minimal header.
    assign w_hdr_last = (r_ihl < 4'd5) ? 16'd19 : (w_hdr_len - 16'd1);
    assign w_tlen16   = 16'(r_tlen);

    // The last header byte is always odd, so it closes a 16-bit word that is
    // folded in combinationally for the accept decision.
    assign w_sum_nxt  = ones_add(r_sum, {r_hi, rx_data});
    assign w_dst_now  = (r_cnt == 16'd19) ? {r_dst[3*OCT-1:0], rx_data} : r_dst;

    assign w_hdr_end  = w_active && (r_state == HEADER) &&
                        (r_cnt != 16'd0) && (r_cnt == w_hdr_last);

    assign w_hdr_ok   = (r_ver == 4'd4) &&
                        (r_ihl >= 4'd5) &&
                        (w_tlen16 >= w_hdr_len) &&
                        (r_proto == PROTO) &&
                        (w_sum_nxt == {W2{1'b1}}) &&
                        ((w_dst_now == my_ip) || (w_dst_now == {(4*OCT){1'b1}}));

    assign w_accept   = w_hdr_end && w_hdr_ok;
    assign w_reject   = w_hdr_end && !w_hdr_ok;
    assign w_pay_last = (r_cnt == (w_tlen16 - 16'd1));
    assign w_fwd      = w_active && (r_state == PAYLOAD);

    // State register
    always_ff @(posedge RX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HEADER;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (!rx_data_v) begin
            w_state_nxt = HEADER;
        end else if (r_armed) begin
            case (r_state)
                HEADER: begin
                    if (w_accept) begin
                        // Header-only datagram: nothing to forward.
                        w_state_nxt = (w_tlen16 == w_hdr_len) ? DROP : PAYLOAD;
                    end else if (w_reject) begin
                        w_state_nxt = DROP;
                    end
                end
                PAYLOAD: begin
                    if (w_pay_last) begin
                        w_state_nxt = DROP;
                    end
                end
                DROP: begin
                    w_state_nxt = DROP;
                end
                default: begin
                    w_state_nxt = HEADER;
                end
            endcase
        end
    end

    // Byte counter, checksum and header field capture
    always_ff @(posedge RX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_sum   <= '0;
            r_hi    <= '0;
            r_ver   <= '0;
            r_ihl   <= '0;
            r_tlen  <= '0;
            r_proto <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_armed <= 1'b0;
        end else if (!rx_data_v) begin
            r_cnt   <= '0;
            r_sum   <= '0;
            r_armed <= 1'b1;
        end else if (r_armed) begin
            r_cnt <= sat_inc(r_cnt);
            if (r_state == HEADER) begin
                if (!r_cnt[0]) begin
                    r_hi <= rx_data;
                end else begin
                    r_sum <= w_sum_nxt;
                end
                if (r_cnt == 16'd0) begin
                    r_ver <= rx_data[7:4];
                    r_ihl <= rx_data[3:0];
                end
                if (r_cnt == 16'd2) begin
                    r_tlen[W2-1:OCT] <= rx_data;
                end
                if (r_cnt == 16'd3) begin
                    r_tlen[OCT-1:0] <= rx_data;
                end
                if (r_cnt == 16'd9) begin
                    r_proto <= rx_data;
                end
                if ((r_cnt >= 16'd12) && (r_cnt <= 16'd15)) begin
                    r_src <= {r_src[3*OCT-1:0], rx_data};
                end
                if ((r_cnt >= 16'd16) && (r_cnt <= 16'd19)) begin
                    r_dst <= {r_dst[3*OCT-1:0], rx_data};
                end
            end
        end
    end

    // Output stage: payload register, drop pulse, source address
    always_ff @(posedge RX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_ip_v    <= 1'b0;
            r_ip_data <= '0;
            r_src_ip  <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_ip_v <= w_fwd;
            if (w_fwd) begin
                r_ip_data <= rx_data;
            end
            r_drop <= w_reject;
            if (w_accept) begin
                r_src_ip <= r_src;
            end
        end
    end

    assign rx_ip_data_v = r_ip_v;
    assign rx_ip_data   = r_ip_data;
    assign rx_src_ip    = r_src_ip;
    assign rx_drop      = r_drop;

endmodule

// File: tb/tb_rx_ipv4.sv
// -----------------------------------------------------------------------------
// tb_rx_ipv4 -- self-checking bench for rx_ipv4
//
// Frames are built as byte queues; a frame-level reference model decides from
// the bytes alone whether the datagram is accepted, rejected or silently lost,
// which payload bytes must come out, and when.
// -----------------------------------------------------------------------------
module tb_rx_ipv4;

    logic        RX_CLK = 1'b0;
    logic        rst_n;
    logic [31:0] my_ip;
    logic        rx_data_v;
    logic [7:0]  rx_data;
    logic        rx_ip_data_v;
    logic [7:0]  rx_ip_data;
    logic [31:0] rx_src_ip;
    logic        rx_drop;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start    = 0;

    logic [7:0]  frm[$];
    logic [7:0]  out_q[$];
    int          out_cyc_q[$];
    int          drop_cyc_q[$];

    // reference model results
    logic [7:0]  exp_q[$];
    bit          exp_drop;
    int          exp_hl;
    int          exp_dec;
    logic [31:0] m_src;

    rx_ipv4 #(.OCT(8), .PROTO(8'h11)) dut (
        .RX_CLK       (RX_CLK),
        .rst_n        (rst_n),
        .my_ip        (my_ip),
        .rx_data_v    (rx_data_v),
        .rx_data      (rx_data),
        .rx_ip_data_v (rx_ip_data_v),
        .rx_ip_data   (rx_ip_data),
        .rx_src_ip    (rx_src_ip),
        .rx_drop      (rx_drop)
    );

    always #5 RX_CLK = ~RX_CLK;

    always @(posedge RX_CLK) cyc <= cyc + 1;

    always @(negedge RX_CLK) begin
        if (rx_ip_data_v === 1'b1) begin
            out_q.push_back(rx_ip_data);
            out_cyc_q.push_back(cyc);
        end
        if (rx_drop === 1'b1) begin
            drop_cyc_q.push_back(cyc);
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic fix_cks(input int hl);
        int s;
        logic [15:0] c;
        frm[10] = 8'h00;
        frm[11] = 8'h00;
        s = 0;
        for (int i = 0; i < hl; i += 2) s += int'({frm[i], frm[i+1]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        c = ~s[15:0];
        frm[10] = c[15:8];
        frm[11] = c[7:0];
    endtask

    task automatic build(input logic [3:0] ver, input logic [3:0] ihl,
                         input int tlen, input logic [7:0] proto,
                         input logic [31:0] src, input logic [31:0] dst,
                         input int npay, input int npad);
        int hl;
        frm.delete();
        hl = (ihl < 4'd5) ? 20 : int'(ihl) * 4;
        frm.push_back({ver, ihl});
        frm.push_back(8'h00);
        frm.push_back(tlen[15:8]);
        frm.push_back(tlen[7:0]);
        frm.push_back(8'($urandom));
        frm.push_back(8'($urandom));
        frm.push_back(8'h40);
        frm.push_back(8'h00);
        frm.push_back(8'h40);
        frm.push_back(proto);
        frm.push_back(8'h00);
        frm.push_back(8'h00);
        for (int i = 3; i >= 0; i--) frm.push_back(src[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) frm.push_back(dst[i*8 +: 8]);
        for (int i = 20; i < hl; i++) frm.push_back(8'($urandom));
        fix_cks(hl);
        for (int i = 0; i < npay + npad; i++) frm.push_back(8'($urandom));
    endtask

    task automatic load_ref_frame();
        logic [7:0] h [20];
        h = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
              8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
        frm.delete();
        for (int i = 0; i < 20; i++) frm.push_back(h[i]);
        for (int i = 0; i < 95; i++) frm.push_back(8'($urandom));
    endtask

    // Frame-level behaviour: decision after the header, payload up to total_len.
    task automatic model_frame();
        int len, ihl, s, tlen;
        logic [31:0] dst;
        bit ok;
        exp_q.delete();
        exp_drop = 1'b0;
        len      = frm.size();
        ihl      = int'(frm[0][3:0]);
        exp_hl   = ihl * 4;
        exp_dec  = (ihl < 5) ? 20 : exp_hl;
        if (len < exp_dec) return;
        s = 0;
        for (int i = 0; i < exp_dec; i += 2) s += int'({frm[i], frm[i+1]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        tlen = int'({frm[2], frm[3]});
        dst  = {frm[16], frm[17], frm[18], frm[19]};
        ok = (frm[0][7:4] == 4'd4) && (ihl >= 5) && (tlen >= exp_hl) &&
             (frm[9] == 8'h11) && (s == 32'hFFFF) &&
             ((dst == my_ip) || (dst == 32'hFFFF_FFFF));
        if (!ok) begin
            exp_drop = 1'b1;
            return;
        end
        m_src = {frm[12], frm[13], frm[14], frm[15]};
        for (int i = exp_hl; (i < tlen) && (i < len); i++) exp_q.push_back(frm[i]);
    endtask

    task automatic send(input int gap);
        out_q.delete();
        out_cyc_q.delete();
        drop_cyc_q.delete();
        @(posedge RX_CLK); #1;
        start = cyc;
        foreach (frm[i]) begin
            rx_data_v = 1'b1;
            rx_data   = frm[i];
            @(posedge RX_CLK); #1;
        end
        rx_data_v = 1'b0;
        repeat (gap) begin
            @(posedge RX_CLK); #1;
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst_n     = 1'b0;
        rx_data_v = 1'b0;
        rx_data   = 8'h00;
        my_ip     = 32'hC0A8_00C7;
        m_src     = 32'h0;
        #2;
        checks++; if (rx_ip_data_v !== 1'b0) begin failures++; $display("FAIL reset_v got=%b exp=0", rx_ip_data_v); end
        checks++; if (rx_ip_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_ip_data); end
        checks++; if (rx_src_ip !== 32'h0) begin failures++; $display("FAIL reset_src got=%h exp=0", rx_src_ip); end
        checks++; if (rx_drop !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", rx_drop); end
        repeat (3) @(posedge RX_CLK);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge RX_CLK);
        #1;
    endtask

    task automatic test_valid();
        my_ip = 32'hC0A8_00C7;
        load_ref_frame();
        model_frame();
        send(3);
        checks++; if (out_q.size() != 95) begin failures++; $display("FAIL valid_count got=%0d exp=95", out_q.size()); end
        for (int k = 0; k < out_q.size() && k < exp_q.size(); k++) begin
            checks++; if (out_q[k] !== exp_q[k]) begin failures++; $display("FAIL valid_byte%0d got=%h exp=%h", k, out_q[k], exp_q[k]); end
            checks++; if (out_cyc_q[k] != start + 21 + k) begin failures++; $display("FAIL valid_time%0d got=%0d exp=%0d", k, out_cyc_q[k] - start, 21 + k); end
        end
        checks++; if (drop_cyc_q.size() != 0) begin failures++; $display("FAIL valid_drop got=%0d exp=0", drop_cyc_q.size()); end
        checks++; if (rx_src_ip !== 32'hC0A8_0001) begin failures++; $display("FAIL valid_src got=%h exp=C0A80001", rx_src_ip); end
    endtask

    task automatic test_bad_cks();
        load_ref_frame();
        frm[11] = 8'h62;
        send(3);
        checks++; if (drop_cyc_q.size() != 1) begin failures++; $display("FAIL badcks_drops got=%0d exp=1", drop_cyc_q.size()); end
        if (drop_cyc_q.size() > 0) begin
            checks++; if (drop_cyc_q[0] != start + 20) begin failures++; $display("FAIL badcks_when got=%0d exp=20", drop_cyc_q[0] - start); end
        end
        checks++; if (out_q.size() != 0) begin failures++; $display("FAIL badcks_out got=%0d exp=0", out_q.size()); end
        checks++; if (rx_src_ip !== 32'hC0A8_0001) begin failures++; $display("FAIL badcks_src got=%h exp=C0A80001", rx_src_ip); end
    endtask

    task automatic test_addr_filter();
        my_ip = 32'hC0A8_0002;
        load_ref_frame();
        send(3);
        checks++; if (drop_cyc_q.size() != 1) begin failures++; $display("FAIL addr_drops got=%0d exp=1", drop_cyc_q.size()); end
        checks++; if (out_q.size() != 0) begin failures++; $display("FAIL addr_out got=%0d exp=0", out_q.size()); end
        load_ref_frame();
        frm[12] = 8'h0A; frm[13] = 8'h00; frm[14] = 8'h00; frm[15] = 8'h05;
        for (int i = 16; i < 20; i++) frm[i] = 8'hFF;
        fix_cks(20);
        model_frame();
        send(3);
        checks++; if (out_q.size() != 95) begin failures++; $display("FAIL bcast_count got=%0d exp=95", out_q.size()); end
        for (int k = 0; k < out_q.size() && k < exp_q.size(); k++) begin
            checks++; if (out_q[k] !== exp_q[k]) begin failures++; $display("FAIL bcast_byte%0d got=%h exp=%h", k, out_q[k], exp_q[k]); end
        end
        checks++; if (drop_cyc_q.size() != 0) begin failures++; $display("FAIL bcast_drop got=%0d exp=0", drop_cyc_q.size()); end
        checks++; if (rx_src_ip !== 32'h0A00_0005) begin failures++; $display("FAIL bcast_src got=%h exp=0A000005", rx_src_ip); end
        my_ip = 32'hC0A8_00C7;
    endtask

    task automatic test_options_pad();
        build(4'd4, 4'd6, 28, 8'h11, 32'h0A0B_0C0D, my_ip, 4, 18);
        send(3);
        checks++; if (out_q.size() != 4) begin failures++; $display("FAIL opt_count got=%0d exp=4", out_q.size()); end
        for (int k = 0; k < out_q.size() && k < 4; k++) begin
            checks++; if (out_q[k] !== frm[24 + k]) begin failures++; $display("FAIL opt_byte%0d got=%h exp=%h", k, out_q[k], frm[24 + k]); end
            checks++; if (out_cyc_q[k] != start + 25 + k) begin failures++; $display("FAIL opt_time%0d got=%0d exp=%0d", k, out_cyc_q[k] - start, 25 + k); end
        end
        checks++; if (rx_src_ip !== 32'h0A0B_0C0D) begin failures++; $display("FAIL opt_src got=%h exp=0A0B0C0D", rx_src_ip); end
        checks++; if (drop_cyc_q.size() != 0) begin failures++; $display("FAIL opt_drop got=%0d exp=0", drop_cyc_q.size()); end
    endtask

    task automatic test_truncate();
        // payload cut after 10 bytes
        build(4'd4, 4'd5, 115, 8'h11, 32'h0102_0304, my_ip, 10, 0);
        send(3);
        checks++; if (out_q.size() != 10) begin failures++; $display("FAIL trunc_count got=%0d exp=10", out_q.size()); end
        if (out_cyc_q.size() > 0) begin
            checks++; if (out_cyc_q[out_cyc_q.size()-1] != start + 30) begin failures++; $display("FAIL trunc_last got=%0d exp=30", out_cyc_q[out_cyc_q.size()-1] - start); end
        end
        checks++; if (rx_ip_data !== frm[29]) begin failures++; $display("FAIL trunc_hold got=%h exp=%h", rx_ip_data, frm[29]); end
        // header cut at byte 12: silent
        build(4'd4, 4'd5, 40, 8'h11, 32'h0909_0909, my_ip, 20, 0);
        frm = frm[0:11];
        send(3);
        checks++; if (drop_cyc_q.size() != 0) begin failures++; $display("FAIL htrunc_drop got=%0d exp=0", drop_cyc_q.size()); end
        checks++; if (out_q.size() != 0) begin failures++; $display("FAIL htrunc_out got=%0d exp=0", out_q.size()); end
        checks++; if (rx_src_ip !== 32'h0102_0304) begin failures++; $display("FAIL htrunc_src got=%h exp=01020304", rx_src_ip); end
    endtask

    task automatic test_reset_mid();
        build(4'd4, 4'd5, 60, 8'h11, 32'h0102_0304, my_ip, 40, 0);
        out_q.delete(); out_cyc_q.delete(); drop_cyc_q.delete();
        @(posedge RX_CLK); #1;
        for (int i = 0; i < 26; i++) begin
            rx_data_v = 1'b1;
            rx_data   = frm[i];
            @(posedge RX_CLK); #1;
        end
        checks++; if (rx_ip_data_v !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%b exp=1", rx_ip_data_v); end
        #2 rst_n = 1'b0;
        m_src = 32'h0;
        #1;
        checks++; if (rx_ip_data_v !== 1'b0) begin failures++; $display("FAIL rmid_v got=%b exp=0", rx_ip_data_v); end
        checks++; if (rx_ip_data !== 8'h00) begin failures++; $display("FAIL rmid_data got=%h exp=00", rx_ip_data); end
        checks++; if (rx_src_ip !== 32'h0) begin failures++; $display("FAIL rmid_src got=%h exp=0", rx_src_ip); end
        @(posedge RX_CLK); #1;
        rst_n = 1'b1;
        out_q.delete(); out_cyc_q.delete(); drop_cyc_q.delete();
        for (int i = 26; i < frm.size(); i++) begin
            rx_data = frm[i];
            @(posedge RX_CLK); #1;
        end
        rx_data_v = 1'b0;
        repeat (3) begin @(posedge RX_CLK); #1; end
        checks++; if (out_q.size() != 0) begin failures++; $display("FAIL rmid_rest_out got=%0d exp=0", out_q.size()); end
        checks++; if (drop_cyc_q.size() != 0) begin failures++; $display("FAIL rmid_rest_drop got=%0d exp=0", drop_cyc_q.size()); end
        build(4'd4, 4'd5, 32, 8'h11, 32'h0506_0708, my_ip, 12, 0);
        model_frame();
        send(3);
        checks++; if (out_q.size() != 12) begin failures++; $display("FAIL rmid_next_count got=%0d exp=12", out_q.size()); end
        for (int k = 0; k < out_q.size() && k < exp_q.size(); k++) begin
            checks++; if (out_q[k] !== exp_q[k]) begin failures++; $display("FAIL rmid_next_byte%0d got=%h exp=%h", k, out_q[k], exp_q[k]); end
        end
        checks++; if (rx_src_ip !== 32'h0506_0708) begin failures++; $display("FAIL rmid_next_src got=%h exp=05060708", rx_src_ip); end
    endtask

    task automatic test_random();
        int kind, ihl, npay, npad, tlen, hl, cut;
        logic [31:0] dst, src;
        logic [7:0] proto;
        logic [3:0] ver;
        for (int n = 0; n < 60; n++) begin
            my_ip = $urandom;
            kind  = $urandom_range(0, 10);
            ihl   = $urandom_range(5, 7);
            npay  = $urandom_range(1, 40);
            npad  = $urandom_range(0, 6);
            src   = $urandom;
            dst   = my_ip;
            proto = 8'h11;
            ver   = 4'd4;
            if (kind == 8) ihl = 4;
            hl    = (ihl < 5) ? 20 : ihl * 4;
            tlen  = hl + npay;
            if (kind == 3) dst = my_ip ^ 32'h0000_0100;
            if (kind == 4) dst = 32'hFFFF_FFFF;
            if (kind == 5) proto = 8'h06;
            if (kind == 6) ver = 4'd6;
            if (kind == 7) tlen = hl - 2;
            if (kind == 10) tlen = hl;
            build(ver, 4'(ihl), tlen, proto, src, dst, npay, npad);
            if (kind == 2) frm[$urandom_range(0, 19)] ^= 8'(1 << $urandom_range(0, 7));
            if (kind == 9) begin
                cut = $urandom_range(1, frm.size());
                frm = frm[0:cut-1];
            end
            model_frame();
            send($urandom_range(2, 4));
            checks++; if (out_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd%0d_count kind=%0d got=%0d exp=%0d", n, kind, out_q.size(), exp_q.size()); end
            for (int k = 0; k < out_q.size() && k < exp_q.size(); k++) begin
                checks++; if (out_q[k] !== exp_q[k]) begin failures++; $display("FAIL rnd%0d_byte%0d got=%h exp=%h", n, k, out_q[k], exp_q[k]); end
                checks++; if (out_cyc_q[k] != start + exp_hl + 1 + k) begin failures++; $display("FAIL rnd%0d_time%0d got=%0d exp=%0d", n, k, out_cyc_q[k] - start, exp_hl + 1 + k); end
            end
            checks++; if (drop_cyc_q.size() != int'(exp_drop)) begin failures++; $display("FAIL rnd%0d_drops kind=%0d got=%0d exp=%0d", n, kind, drop_cyc_q.size(), exp_drop); end
            if (exp_drop && drop_cyc_q.size() > 0) begin
                checks++; if (drop_cyc_q[0] != start + exp_dec) begin failures++; $display("FAIL rnd%0d_dropwhen got=%0d exp=%0d", n, drop_cyc_q[0] - start, exp_dec); end
            end
            checks++; if (rx_src_ip !== m_src) begin failures++; $display("FAIL rnd%0d_src got=%h exp=%h", n, rx_src_ip, m_src); end
        end
    endtask

    initial begin
        test_reset();
        test_valid();
        test_bad_cks();
        test_addr_filter();
        test_options_pad();
        test_truncate();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_ipv4.md
RX_IPV4 -- requirements
Module: rx_ipv4

Interface
REQ-001 SHALL have parameter OCT, default 8, giving the byte width of the data path.
REQ-002 SHALL have parameter PROTO, default 8'h11 (UDP), giving the accepted IPv4 protocol number.
REQ-003 SHALL have port RX_CLK, input, 1 bit: the receive clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port my_ip, input, OCT*4 bits: the local IPv4 address, quasi-static.
REQ-006 SHALL have port rx_data_v, input, 1 bit: high for the whole IPv4 datagram (Ethertype already stripped); low for at least 1 cycle between frames.
REQ-007 SHALL have port rx_data, input, OCT bits: the datagram byte, MSB-first network order.
REQ-008 SHALL have port rx_ip_data_v, output, 1 bit: high while the payload byte is valid; contiguous per datagram; feeds rx_udp rx_data_v.
REQ-009 SHALL have port rx_ip_data, output, OCT bits: the payload byte; feeds rx_udp rx_data.
REQ-010 SHALL have port rx_src_ip, output, OCT*4 bits: the source address of the last accepted datagram.
REQ-011 SHALL have port rx_drop, output, 1 bit: a 1-cycle pulse when a header is rejected.

Function
REQ-012 SHALL count input bytes per frame with a 16-bit byte_cnt that is 0 at the first byte while rx_data_v is high.
REQ-013 SHALL use states HEADER, PAYLOAD and DROP, where HEADER covers bytes 0..IHL*4-1, options included.
REQ-014 SHALL capture fields in HEADER: byte 0 gives version[7:4] and IHL[3:0]; bytes 2-3 give total_len; byte 9 gives protocol; bytes 12-15 give src; bytes 16-19 give dst. Option bytes are covered only by the checksum.
REQ-015 SHALL compute the header checksum as the one's-complement sum of 16-bit big-endian words over IHL*4 bytes, folding end-around carry on every add; the header passes when the sum is 16'hFFFF.
REQ-016 SHALL make the accept decision in the cycle of byte IHL*4-1, including that byte combinationally.
REQ-017 SHALL accept the header only when all of the following hold:
- version==4;
- IHL>=5;
- total_len>=IHL*4;
- protocol==PROTO;
- checksum passes;
- dst==my_ip or dst==32'hFFFFFFFF.
REQ-018 SHALL, on accept, go to PAYLOAD and load rx_src_ip in the same edge; if total_len==IHL*4, it SHALL go to DROP with no rx_drop pulse.
REQ-019 SHALL, on reject, go to DROP, pulse rx_drop for 1 cycle, and leave rx_src_ip unchanged.
REQ-020 SHALL, if byte 0 shows IHL<5, reject at byte 19.
REQ-021 SHALL, in PAYLOAD, register each input byte to rx_ip_data with rx_ip_data_v=1, giving a latency of 1 cycle.
REQ-022 SHALL end PAYLOAD when byte total_len-1 has been forwarded, then go to DROP; Ethernet padding and FCS SHALL NOT be forwarded.
REQ-023 SHALL hold rx_ip_data_v=0 in DROP until rx_data_v falls.
REQ-024 SHALL, whenever rx_data_v=0, return the state to HEADER, clear byte_cnt and the checksum accumulator, and drive rx_ip_data_v=0 on the next edge.
REQ-025 SHALL, when a frame is truncated mid-HEADER, discard it silently with no rx_drop.
REQ-026 SHALL, when a frame is truncated mid-PAYLOAD, deassert rx_ip_data_v 1 cycle after rx_data_v falls.
REQ-027 SHALL saturate byte_cnt at 16'hFFFF; no wrap-around.
REQ-028 SHALL hold rx_ip_data at its last value when rx_ip_data_v=0.

Reset
REQ-029 SHALL, on rst_n=0, immediately and asynchronously clear:
- state to HEADER;
- byte_cnt, checksum accumulator and captured fields to 0;
- rx_ip_data_v, rx_drop to 0;
- rx_ip_data to 0;
- rx_src_ip to 0.
REQ-030 SHALL, on reset mid-frame, discard the remainder; after rst_n rises, parsing restarts only after rx_data_v has been observed low.

Verification
REQ-031 SHALL cover a valid datagram: header 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7 plus 95 payload bytes, my_ip=C0A800C7 -> 95 contiguous rx_ip_data_v cycles starting 1 cycle after input byte 20, and rx_src_ip=C0A80001.
REQ-032 SHALL cover a bad checksum: same frame with byte 11 set to 62 -> rx_drop pulses once at byte 19+1 cycle, and rx_ip_data_v stays 0.
REQ-033 SHALL cover address filtering:
- same frame with my_ip=C0A80002 -> rx_drop;
- dst rewritten to FF FF FF FF with checksum fixed -> accepted, 95 bytes out.
REQ-034 SHALL cover options and padding: IHL=6 (24-byte header), total_len=0x001C, 4 payload bytes, then 18 pad bytes -> exactly 4 bytes forwarded, first 1 cycle after byte 24.
REQ-035 SHALL cover truncation and reset:
- rx_data_v drops after payload byte 10 -> rx_ip_data_v low the next cycle;
- rst_n pulsed mid-payload -> outputs 0 immediately, and the next valid frame parses correctly.
